sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter_pkg.sv | 28 ++
 rtl/sram_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter_pkg
//   Shared types and defaults for the SRAM port arbiter.
//   - AW_DEFAULT / DW_DEFAULT : default SRAM address / data widths
//   - cpu_state_e             : CPU-side handshake FSM states
//   - tag_e                   : owner of an SRAM read travelling down the
//                               two-stage return pipeline
// ---------------------------------------------------------------------------
package sram_port_arbiter_pkg;

  localparam int AW_DEFAULT = 11;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [2:0] {
    CPU_IDLE,
    CPU_PEND,
    CPU_RD_WAIT,
    CPU_WR_WAIT,
    CPU_ACK
  } cpu_state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_CPU
  } tag_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one synchronous SRAM port between a video read stream and a CPU
//   with an asynchronous-style CS_n/DTACK_n handshake. Video reads have
//   absolute priority and are pipelined at one per cycle; the CPU waits in
//   PEND until a cycle without a video request.
//
//   Ports
//     i_MCLK, i_RST       : clock, synchronous active-high reset
//     i_VID_REQ/ADDR      : video read strobe and address
//     o_VID_DOUT/VALID    : video read data and one-cycle valid strobe
//     i_CPU_CS_n/RW/ADDR/DIN : CPU request (held until DTACK_n), 1 = read
//     o_CPU_DOUT/DTACK_n  : CPU read data and access-complete strobe
//     o_SRAM_*            : registered SRAM address, data and strobes
//     i_SRAM_DOUT         : SRAM read data, valid two edges after issue
// ---------------------------------------------------------------------------
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          i_MCLK,
  input  logic          i_RST,
  // video side
  input  logic          i_VID_REQ,
  input  logic [AW-1:0] i_VID_ADDR,
  output logic [DW-1:0] o_VID_DOUT,
  output logic          o_VID_VALID,
  // CPU side
  input  logic          i_CPU_CS_n,
  input  logic          i_CPU_RW,
  input  logic [AW-1:0] i_CPU_ADDR,
  input  logic [DW-1:0] i_CPU_DIN,
  output logic [DW-1:0] o_CPU_DOUT,
  output logic          o_CPU_DTACK_n,
  // SRAM side
  output logic [AW-1:0] o_SRAM_ADDR,
  output logic [DW-1:0] o_SRAM_DIN,
  output logic          o_SRAM_WR_n,
  output logic          o_SRAM_RD_n,
  input  logic [DW-1:0] i_SRAM_DOUT
);

  cpu_state_e    state_q, state_d;
  tag_e          tag1_q, tag1_d;   // owner of the read issued on the last edge
  tag_e          tag2_q;           // owner of the data the SRAM presents now
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0] sram_din_q, sram_din_d;
  logic          sram_wr_n_q, sram_rd_n_q;
  logic [DW-1:0] vid_dout_q, cpu_dout_q;
  logic          vid_valid_q, dtack_n_q;

  logic          cpu_issue;
  logic          cpu_rd_issue;
  logic          cpu_wr_issue;

  assign cpu_rd_issue = cpu_issue &  i_CPU_RW;
  assign cpu_wr_issue = cpu_issue & ~i_CPU_RW;

  // CPU FSM next state and issue decision.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    cpu_issue = 1'b0;
    case (state_q)
      CPU_IDLE: begin
        if (!i_CPU_CS_n) state_d = CPU_PEND;
      end
      CPU_PEND: begin
        // Video owns any edge on which it requests; the CPU takes the first
        // free one.
        if (!i_VID_REQ) begin
          cpu_issue = 1'b1;
          state_d   = i_CPU_RW ? CPU_RD_WAIT : CPU_WR_WAIT;
        end
      end
      CPU_RD_WAIT: begin
        // The CPU tag reaches stage 2 exactly one edge after issue, so the
        // data is captured on the second edge after issue.
        if (tag2_q == TAG_CPU) state_d = CPU_ACK;
      end
      CPU_WR_WAIT: begin
        state_d = CPU_ACK;
      end
      CPU_ACK: begin
        // Holding CS_n low parks here; nothing re-issues until a new request.
        if (i_CPU_CS_n) state_d = CPU_IDLE;
      end
      default: begin
        state_d = CPU_IDLE;
      end
    endcase
  end

  // Issue-side datapath: address, write data and read ownership tag.
  always_comb begin
    tag1_d      = TAG_NONE;
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    if (i_VID_REQ) begin
      tag1_d      = TAG_VID;
      sram_addr_d = i_VID_ADDR;
    end else if (cpu_issue) begin
      sram_addr_d = i_CPU_ADDR;
      if (cpu_rd_issue) tag1_d = TAG_CPU;
    end
    if (cpu_wr_issue) sram_din_d = i_CPU_DIN;
  end

  // All state and registered outputs. Reset clears the tag pipeline so any
  // read in flight at reset is dropped instead of producing VALID/DTACK.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q     <= CPU_IDLE;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      sram_wr_n_q <= 1'b1;
      sram_rd_n_q <= 1'b1;
      vid_dout_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= '0;
      dtack_n_q   <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of the others.
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      sram_rd_n_q <= ~(i_VID_REQ | cpu_rd_issue);
      sram_wr_n_q <= ~cpu_wr_issue;
      vid_valid_q <= (tag2_q == TAG_VID);
      if (tag2_q == TAG_VID) vid_dout_q <= i_SRAM_DOUT;
      if (tag2_q == TAG_CPU) cpu_dout_q <= i_SRAM_DOUT;
      // DTACK_n falls on the edge entering ACK and rises on the edge leaving.
      dtack_n_q   <= (state_d != CPU_ACK);
    end
  end

  assign o_SRAM_ADDR   = sram_addr_q;
  assign o_SRAM_DIN    = sram_din_q;
  assign o_SRAM_WR_n   = sram_wr_n_q;
  assign o_SRAM_RD_n   = sram_rd_n_q;
  assign o_VID_DOUT    = vid_dout_q;
  assign o_VID_VALID   = vid_valid_q;
  assign o_CPU_DOUT    = cpu_dout_q;
  assign o_CPU_DTACK_n = dtack_n_q;

endmodule
